// File: rtl/timer_bank.sv
// Multi-channel countdown timer bank with per-channel one-shot/auto-reload FSM and maskable IRQ.
// Optional clock prescaler per channel is built only when TIMER_BANK_PRESCALE_EN is defined.
module timer_bank #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [CH_W+1:0]   ADD_I,
    input  logic [31:0]       DAT_I,
    input  logic              WE_I,
    output logic [31:0]       DAT_O,
    output logic [NUM_CH-1:0] IRQ,
    output logic              IRQ_ANY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    logic [CH_W-1:0]  w_ch;
    logic [1:0]       w_reg;
    logic             w_ch_ok;
    logic [3:0][31:0] w_rd [NUM_CH];
    logic             w_unused;

    assign w_ch     = ADD_I[CH_W+1:2];
    assign w_reg    = ADD_I[1:0];
    assign w_ch_ok  = (32'(w_ch) < 32'(NUM_CH));
    assign w_unused = &{1'b0, DAT_I};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic             r_en;
        logic             r_im;
        logic [1:0]       r_mode;
        logic [WIDTH-1:0] r_preset;
        logic [WIDTH-1:0] r_count;
        logic             r_pend;
        logic [7:0]       w_presc_rd;
        logic             w_sel;
        logic             w_wr_ctrl;
        logic             w_wr_pre;
        logic             w_wr_stat;
        logic             w_tick;
        logic             w_reload;
        logic             w_load;
        logic             w_dec;
        logic             w_set;
        logic             w_clr_en;

        assign w_sel     = WE_I && w_ch_ok && (w_ch == CH_W'(g));
        assign w_wr_ctrl = w_sel && (w_reg == 2'd0);
        assign w_wr_pre  = w_sel && (w_reg == 2'd1);
        assign w_wr_stat = w_sel && (w_reg == 2'd3);
        assign w_reload  = (r_mode == 2'b01);

`ifdef TIMER_BANK_PRESCALE_EN
        logic [7:0] r_presc;
        logic [7:0] r_psc;

        assign w_tick     = (r_psc == r_presc);
        assign w_presc_rd = r_presc;

        // Prescaler restarts at LOAD and only advances while actively counting.
        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                r_presc <= 8'd0;
                r_psc   <= 8'd0;
            end else begin
                if (w_wr_ctrl) r_presc <= DAT_I[11:4];
                if (w_load) begin
                    r_psc <= 8'd0;
                end else if (r_state == S_CNT && r_en) begin
                    r_psc <= w_tick ? 8'd0 : r_psc + 8'd1;
                end
            end
        end
`else
        assign w_tick     = 1'b1;
        assign w_presc_rd = 8'd0;
`endif

        always_comb begin
            w_state_nxt = r_state;
            w_load      = 1'b0;
            w_dec       = 1'b0;
            w_set       = 1'b0;
            w_clr_en    = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_en) w_state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CNT;
                end
                S_CNT: begin
                    if (!r_en) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_tick) begin
                        if (r_count > WIDTH'(1)) begin
                            w_dec = 1'b1;
                        end else begin
                            w_set       = 1'b1;
                            w_state_nxt = S_INT;
                        end
                    end
                end
                S_INT: begin
                    if (w_reload) begin
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_clr_en    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        // CTRL writes outrank the one-shot EN clear; a PEND set outranks any clear.
        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                r_state  <= S_IDLE;
                r_en     <= 1'b0;
                r_im     <= 1'b0;
                r_mode   <= 2'b00;
                r_preset <= '0;
                r_count  <= '0;
                r_pend   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                if (w_wr_ctrl) begin
                    r_en   <= DAT_I[0];
                    r_mode <= DAT_I[2:1];
                    r_im   <= DAT_I[3];
                end else if (w_clr_en) begin
                    r_en <= 1'b0;
                end
                if (w_wr_pre) r_preset <= DAT_I[WIDTH-1:0];
                if (w_load) begin
                    r_count <= (r_preset == '0) ? WIDTH'(1) : r_preset;
                end else if (w_dec) begin
                    r_count <= r_count - WIDTH'(1);
                end else if (w_set) begin
                    r_count <= '0;
                end
                if (w_set) begin
                    r_pend <= 1'b1;
                end else if (w_wr_ctrl || (w_wr_stat && DAT_I[0])) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign w_rd[g][0] = {20'd0, w_presc_rd, r_im, r_mode, r_en};
        assign w_rd[g][1] = 32'(r_preset);
        assign w_rd[g][2] = 32'(r_count);
        assign w_rd[g][3] = {31'd0, r_pend};
        assign IRQ[g]     = r_pend & r_im;
    end

    always_comb begin
        DAT_O = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch_ok && (32'(w_ch) == 32'(i))) DAT_O = w_rd[i][w_reg];
        end
    end

    assign IRQ_ANY = |IRQ;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: edge-timestamp reference model checked every cycle,
// plus hand-computed literal checks. Honours TIMER_BANK_PRESCALE_EN like the design.
module tb_timer_bank;

    localparam int NCH = 5;
    localparam int WID = 16;
    localparam int CHW = 3;

    logic           clk;
    logic           clr = 1'b0;
    logic [CHW+1:0] ADD_I = '0;
    logic [31:0]    DAT_I = '0;
    logic           WE_I = 1'b0;
    logic [31:0]    DAT_O;
    logic [NCH-1:0] IRQ;
    logic           IRQ_ANY;

    int checks = 0;
    int errors = 0;

    timer_bank #(.NUM_CH(NCH), .WIDTH(WID)) dut (
        .clk    (clk),
        .clr    (clr),
        .ADD_I  (ADD_I),
        .DAT_I  (DAT_I),
        .WE_I   (WE_I),
        .DAT_O  (DAT_O),
        .IRQ    (IRQ),
        .IRQ_ANY(IRQ_ANY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each run is described by the edge it loads and the edge it expires.
    bit        m_en     [NCH];
    bit [1:0]  m_mode   [NCH];
    bit        m_im     [NCH];
    bit [7:0]  m_presc  [NCH];
    bit [31:0] m_preset [NCH];
    bit [31:0] m_count  [NCH];
    bit        m_pend   [NCH];
    bit        m_active [NCH];
    int        m_load_edge [NCH];
    int        m_done_edge [NCH];
    int        m_load_val  [NCH];
    int        n_edge = 0;
    bit        set_p;
    bit        drop_en;

    function automatic int div_of(input int c);
`ifdef TIMER_BANK_PRESCALE_EN
        return int'(m_presc[c]) + 1;
`else
        return 1;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [CHW+1:0] a);
        int c;
        c = int'(a[CHW+1:2]);
        if (c >= NCH) return 32'd0;
        case (a[1:0])
            2'd0:    return {20'd0, m_presc[c], m_im[c], m_mode[c], m_en[c]};
            2'd1:    return m_preset[c];
            2'd2:    return m_count[c];
            default: return {31'd0, m_pend[c]};
        endcase
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_presc[c] = 0;
                m_preset[c] = 0; m_count[c] = 0; m_pend[c] = 0; m_active[c] = 0;
                m_load_edge[c] = -10; m_done_edge[c] = -10; m_load_val[c] = 0;
            end
        end else begin
            n_edge++;
            for (int c = 0; c < NCH; c++) begin
                set_p = 0;
                drop_en = 0;
                if (!m_active[c]) begin
                    if (m_en[c]) begin
                        m_active[c] = 1;
                        m_load_edge[c] = n_edge + 1;
                        m_done_edge[c] = -10;
                    end
                end else if (n_edge == m_load_edge[c]) begin
                    m_load_val[c] = (m_preset[c] == 0) ? 1 : int'(m_preset[c]);
                    m_count[c] = 32'(m_load_val[c]);
                    m_done_edge[c] = n_edge + m_load_val[c] * div_of(c);
                end else if (n_edge == m_done_edge[c] + 1) begin
                    if (m_mode[c] == 2'b01) m_load_edge[c] = n_edge + 1;
                    else begin
                        m_active[c] = 0;
                        drop_en = 1;
                    end
                end else if (!m_en[c]) begin
                    m_active[c] = 0;
                end else begin
                    m_count[c] = 32'(m_load_val[c] - (n_edge - m_load_edge[c]) / div_of(c));
                    if (n_edge == m_done_edge[c]) set_p = 1;
                end
                if (drop_en) m_en[c] = 0;
                if (WE_I && int'(ADD_I[CHW+1:2]) == c) begin
                    case (ADD_I[1:0])
                        2'd0: begin
                            m_en[c] = DAT_I[0];
                            m_mode[c] = DAT_I[2:1];
                            m_im[c] = DAT_I[3];
`ifdef TIMER_BANK_PRESCALE_EN
                            m_presc[c] = DAT_I[11:4];
`endif
                            m_pend[c] = 0;
                        end
                        2'd1: m_preset[c] = DAT_I & 32'h0000_FFFF;
                        2'd3: if (DAT_I[0]) m_pend[c] = 0;
                        default: ;
                    endcase
                end
                if (set_p) m_pend[c] = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: interrupt lines and read data against the model.
    always @(negedge clk) begin
        logic [NCH-1:0] e_irq;
        for (int c = 0; c < NCH; c++) e_irq[c] = m_pend[c] & m_im[c];
        chk("cyc_irq", 32'(IRQ), 32'(e_irq));
        chk("cyc_irq_any", 32'(IRQ_ANY), 32'(|e_irq));
        chk("cyc_dat_o", DAT_O, model_read(ADD_I));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] d);
        ADD_I = {3'(ch), 2'(rg)};
        DAT_I = d;
        WE_I  = 1'b1;
        @(posedge clk);
        #1;
        WE_I  = 1'b0;
    endtask

    task automatic chk_reg(input string name, input int ch, input int rg, input logic [31:0] exp);
        ADD_I = {3'(ch), 2'(rg)};
        #1;
        chk(name, DAT_O, exp);
    endtask

    initial begin
        int pe;
`ifdef TIMER_BANK_PRESCALE_EN
        pe = 10;
`else
        pe = 4;
`endif
        step(2);
        chk("rst_irq", 32'(IRQ), 32'd0);
        chk_reg("rst_ctrl0", 0, 0, 32'd0);
        chk_reg("rst_cnt1", 1, 2, 32'd0);
        clr = 1'b1;
        step(1);

        // One-shot, ch1, PRESET=5, IM=1
        wr(1, 1, 32'd5);
        wr(1, 0, 32'h9);
        step(2);
        chk_reg("os_cnt_load", 1, 2, 32'd5);
        step(4);
        chk("os_irq_early", 32'(IRQ), 32'd0);
        chk_reg("os_cnt_1", 1, 2, 32'd1);
        step(1);
        chk("os_irq", 32'(IRQ), 32'h02);
        chk("os_irq_any", 32'(IRQ_ANY), 32'd1);
        chk_reg("os_cnt_0", 1, 2, 32'd0);
        step(1);
        chk_reg("os_en_clr", 1, 0, 32'h8);
        wr(1, 3, 32'd1);
        chk_reg("os_w1c", 1, 3, 32'd0);

        // One-shot with PRESET=0 and re-enable written during INT, ch3
        wr(3, 1, 32'd0);
        wr(3, 0, 32'h1);
        step(3);
        chk_reg("p0_pend", 3, 3, 32'd1);
        wr(3, 0, 32'h1);
        chk_reg("int_en_wins", 3, 0, 32'h1);
        chk_reg("ctrl_clr_pend", 3, 3, 32'd0);
        step(3);
        chk_reg("rearm_pend", 3, 3, 32'd1);
        step(2);
        chk_reg("rearm_en_clr", 3, 0, 32'h0);
        wr(3, 3, 32'd1);

        // Auto-reload, ch0, PRESET=3 -> PEND every 5 cycles
        wr(0, 1, 32'd3);
        wr(0, 0, 32'hB);
        step(5);
        chk_reg("ar_pend1", 0, 3, 32'd1);
        chk("ar_irq1", 32'(IRQ), 32'h01);
        wr(0, 3, 32'd1);
        chk_reg("ar_w1c", 0, 3, 32'd0);
        step(3);
        wr(0, 3, 32'd1);
        chk_reg("ar_set_wins", 0, 3, 32'd1);
        wr(0, 3, 32'd1);
        chk_reg("ar_w1c2", 0, 3, 32'd0);
        wr(0, 1, 32'd2);
        chk_reg("ar_old_preset", 0, 2, 32'd3);
        step(3);
        chk_reg("ar_pend3", 0, 3, 32'd1);
        wr(0, 3, 32'd1);
        step(2);
        chk_reg("ar_new_p_early", 0, 3, 32'd0);
        step(1);
        chk_reg("ar_new_p_pend", 0, 3, 32'd1);
        wr(0, 0, 32'h0);
        chk_reg("ar_stop_pend", 0, 3, 32'd0);
        step(3);

        // Masked interrupt and mid-count disable, ch2
        wr(2, 1, 32'd2);
        wr(2, 0, 32'h1);
        step(4);
        chk_reg("mask_pend", 2, 3, 32'd1);
        chk("mask_irq", 32'(IRQ), 32'd0);
        wr(2, 0, 32'h0);
        wr(2, 1, 32'd10);
        wr(2, 0, 32'h1);
        step(4);
        wr(2, 0, 32'h0);
        step(5);
        chk_reg("dis_hold", 2, 2, 32'd7);
        chk_reg("dis_nopend", 2, 3, 32'd0);

        // Address decode
        wr(5, 1, 32'd123);
        wr(5, 0, 32'h9);
        wr(7, 1, 32'd77);
        chk_reg("oob_pre", 5, 1, 32'd0);
        chk_reg("oob_ctrl", 5, 0, 32'd0);
        chk_reg("oob_keep", 1, 1, 32'd5);
        wr(1, 2, 32'hAA);
        chk_reg("cnt_ro", 1, 2, 32'd0);
        wr(4, 1, 32'hFFFF_1234);
        chk_reg("preset_width", 4, 1, 32'h1234);

        // Prescaled one-shot, ch4, PRESET=2, PRESC=3
        wr(4, 1, 32'd2);
        wr(4, 0, 32'h39);
        step(pe - 1);
        chk_reg("psc_early", 4, 3, 32'd0);
        step(1);
        chk_reg("psc_pend", 4, 3, 32'd1);
        chk("psc_irq", 32'(IRQ), 32'h10);
`ifdef TIMER_BANK_PRESCALE_EN
        chk_reg("psc_ctrl", 4, 0, 32'h39);
`else
        chk_reg("psc_ctrl", 4, 0, 32'h09);
`endif
        wr(4, 3, 32'd1);
        step(2);

        // Asynchronous reset mid-count with IRQ high
        wr(1, 1, 32'd20);
        wr(1, 0, 32'h9);
        wr(0, 1, 32'd1);
        wr(0, 0, 32'hB);
        step(3);
        chk("pre_rst_irq_any", 32'(IRQ_ANY), 32'd1);
        clr = 1'b0;
        #1;
        chk("async_irq", 32'(IRQ), 32'd0);
        chk("async_irq_any", 32'(IRQ_ANY), 32'd0);
        chk_reg("async_ctrl", 1, 0, 32'd0);
        step(2);
        clr = 1'b1;
        step(6);
        chk_reg("post_rst_cnt", 1, 2, 32'd0);
        chk_reg("post_rst_pend", 0, 3, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
